snake_hud_controller: RTL and testbench

SNAKE_HUD_CONTROLLER -- requirements
Module: snake_hud_controller

---
 rtl/snake_hud_pkg.sv | 55 +++++
 rtl/hud_seg7_decoder.sv | 35 +++
 rtl/snake_hud_controller.sv | 209 ++++++++++++++++++++
 tb/tb_snake_hud_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_hud_pkg.sv
// Shared definitions for the snake HUD: play-state codes, FSM states, glyph codes,
// active-low 7-segment patterns ({g,f,e,d,c,b,a}) and a constant binary-to-BCD helper.
package snake_hud_pkg;

   typedef enum logic [1:0] {
      PS_IDLE = 2'b00,
      PS_PLAY = 2'b01,
      PS_WIN  = 2'b10,
      PS_FAIL = 2'b11
   } play_state_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_EXPIRED
   } hud_state_t;

   // Glyph codes 0..9 are the decimal digits themselves.
   typedef enum logic [4:0] {
      GL_A     = 5'd10,
      GL_F     = 5'd11,
      GL_I     = 5'd12,
      GL_L     = 5'd13,
      GL_BLANK = 5'd31
   } glyph_t;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_I     = 7'h4F;
   localparam logic [6:0] SEG_L     = 7'h47;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [15:0] bin_to_bcd16(input int unsigned value);
      logic [15:0] bcd;
      int unsigned v;
      bcd = '0;
      v   = value;
      for (int i = 0; i < 4; i++) begin
         bcd[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return bcd;
   endfunction

endpackage

// File: rtl/hud_seg7_decoder.sv
// Combinational glyph-to-segment decoder; output is active-low with the dot on bit 7.
module hud_seg7_decoder
   import snake_hud_pkg::*;
(
   input  logic [4:0] i_glyph,
   input  logic       i_dot,
   output logic [7:0] o_seg
);

   logic [6:0] w_seg7;

   always_comb begin
      w_seg7 = SEG_BLANK;
      case (i_glyph)
         5'd0:    w_seg7 = SEG_0;
         5'd1:    w_seg7 = SEG_1;
         5'd2:    w_seg7 = SEG_2;
         5'd3:    w_seg7 = SEG_3;
         5'd4:    w_seg7 = SEG_4;
         5'd5:    w_seg7 = SEG_5;
         5'd6:    w_seg7 = SEG_6;
         5'd7:    w_seg7 = SEG_7;
         5'd8:    w_seg7 = SEG_8;
         5'd9:    w_seg7 = SEG_9;
         GL_A:    w_seg7 = SEG_A;
         GL_F:    w_seg7 = SEG_F;
         GL_I:    w_seg7 = SEG_I;
         GL_L:    w_seg7 = SEG_L;
         default: w_seg7 = SEG_BLANK;
      endcase
   end

   assign o_seg = {~i_dot, w_seg7};

endmodule

// File: rtl/snake_hud_controller.sv
// Snake HUD: game timer, BCD score and multiplexed 7-segment display.
// Optional macro HUD_HIGHSCORE_EN adds a best-score register shown while idle.
//
// state      | meaning
// ST_IDLE    | no game running; timer and score frozen
// ST_RUN     | game in progress; timer counts while PLAY_STATE is play
// ST_EXPIRED | timer reached zero; TIME_IS_UP held until next game
module snake_hud_controller
   import snake_hud_pkg::*;
#(
   parameter  int SCORE_DIGITS = 2,
   parameter  int TIME_DIGITS  = 2,
   parameter  int GAME_SECONDS = 60,
   parameter  int SEC_DIV      = 100000000,
   parameter  int STROBE_DIV   = 100000,
   localparam int NUM_DIGITS   = SCORE_DIGITS + TIME_DIGITS
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [1:0]                PLAY_STATE,
   input  logic                      REACHED_TARGET,
   output logic [NUM_DIGITS-1:0]     SEG_SELECT,
   output logic [7:0]                DEC_OUT,
   output logic [4*SCORE_DIGITS-1:0] SCORE,
   output logic [4*TIME_DIGITS-1:0]  TIME_LEFT,
   output logic                      TIME_IS_UP
);

   localparam int SEC_W = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
   localparam int STB_W = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
   localparam int DIG_W = $clog2(NUM_DIGITS);
   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_DIV - 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE_DIV - 1);
   localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
   localparam logic [4*TIME_DIGITS-1:0] TIME_INIT = (4*TIME_DIGITS)'(bin_to_bcd16(GAME_SECONDS));

   if (NUM_DIGITS < 4 || NUM_DIGITS > 8) begin : g_bad_num_digits
      $error("snake_hud_controller: SCORE_DIGITS+TIME_DIGITS must be 4..8");
   end
   if (SCORE_DIGITS < 1 || SCORE_DIGITS > 4 || TIME_DIGITS < 2 || TIME_DIGITS > 4) begin : g_bad_digits
      $error("snake_hud_controller: digit count out of range");
   end
   if (GAME_SECONDS < 0 || GAME_SECONDS >= 10**TIME_DIGITS) begin : g_bad_seconds
      $error("snake_hud_controller: GAME_SECONDS does not fit TIME_DIGITS");
   end

   hud_state_t                r_state, w_state_nxt;
   logic [1:0]                r_play_prev;
   logic [SEC_W-1:0]          r_sec_cnt;
   logic [STB_W-1:0]          r_stb_cnt;
   logic [DIG_W-1:0]          r_digit;
   logic [4*SCORE_DIGITS-1:0] r_score, w_score_inc, w_score_show;
   logic                      w_score_full;
   logic [4*TIME_DIGITS-1:0]  r_time, w_time_dec;
   logic                      r_time_up;
   logic [NUM_DIGITS-1:0]     r_seg_select;
   logic [7:0]                r_dec_out, w_seg;
   logic [3:0]                w_nib [NUM_DIGITS];
   logic [4:0]                w_glyph;
   logic                      w_dot, w_in_play, w_run_entry, w_counting;

   assign w_in_play   = (PLAY_STATE == PS_PLAY);
   assign w_run_entry = w_in_play && (r_play_prev != PS_PLAY);
   assign w_counting  = (r_state == ST_RUN) && w_in_play;

   always_comb begin
      w_state_nxt = r_state;
      if (w_run_entry)
         w_state_nxt = ST_RUN;
      else if (PLAY_STATE == PS_IDLE)
         w_state_nxt = ST_IDLE;
      else if (r_state == ST_RUN && r_time == '0)
         w_state_nxt = ST_EXPIRED;
   end

   always_comb begin
      logic w_carry;
      w_carry      = 1'b1;
      w_score_full = 1'b1;
      w_score_inc  = r_score;
      for (int i = 0; i < SCORE_DIGITS; i++) begin
         if (r_score[4*i +: 4] != 4'd9) w_score_full = 1'b0;
         if (w_carry) begin
            if (r_score[4*i +: 4] == 4'd9) begin
               w_score_inc[4*i +: 4] = 4'd0;
            end else begin
               w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
               w_carry = 1'b0;
            end
         end
      end
   end

   always_comb begin
      logic w_borrow;
      w_borrow   = 1'b1;
      w_time_dec = r_time;
      for (int i = 0; i < TIME_DIGITS; i++) begin
         if (w_borrow) begin
            if (r_time[4*i +: 4] == 4'd0) begin
               w_time_dec[4*i +: 4] = 4'd9;
            end else begin
               w_time_dec[4*i +: 4] = r_time[4*i +: 4] - 4'd1;
               w_borrow = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= ST_IDLE;
         r_play_prev <= PS_PLAY;  // forces a fresh non-play -> play edge after reset
         r_score     <= '0;
         r_time      <= TIME_INIT;
         r_time_up   <= 1'b0;
         r_sec_cnt   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_play_prev <= PLAY_STATE;
         if (w_run_entry) begin
            r_score   <= '0;
            r_time    <= TIME_INIT;
            r_time_up <= 1'b0;
            r_sec_cnt <= '0;
         end else begin
            if (w_counting) begin
               if (r_sec_cnt == SEC_LAST) begin
                  r_sec_cnt <= '0;
                  if (r_time != '0) r_time <= w_time_dec;
               end else begin
                  r_sec_cnt <= r_sec_cnt + SEC_W'(1);
               end
            end
            if (w_counting && REACHED_TARGET && !w_score_full) r_score <= w_score_inc;
            if (r_state == ST_RUN && r_time == '0) r_time_up <= 1'b1;
         end
      end
   end

`ifdef HUD_HIGHSCORE_EN
   logic [4*SCORE_DIGITS-1:0] r_best;

   // BCD ordering matches binary ordering, so a plain compare picks the larger score.
   always_ff @(posedge CLK) begin
      if (RESET)
         r_best <= '0;
      else if (r_state != ST_IDLE && (w_run_entry || w_state_nxt == ST_IDLE) && r_score > r_best)
         r_best <= r_score;
   end

   assign w_score_show = (r_state == ST_IDLE) ? r_best : r_score;
`else
   assign w_score_show = r_score;
`endif

   always_comb begin
      for (int i = 0; i < SCORE_DIGITS; i++) w_nib[i] = w_score_show[4*i +: 4];
      for (int i = 0; i < TIME_DIGITS; i++) w_nib[SCORE_DIGITS+i] = r_time[4*i +: 4];
   end

   always_comb begin
      w_glyph = GL_BLANK;
      w_dot   = 1'b0;
      if (PLAY_STATE == PS_FAIL) begin
         case (r_digit)
            DIG_W'(0): w_glyph = GL_L;
            DIG_W'(1): w_glyph = GL_I;
            DIG_W'(2): w_glyph = GL_A;
            DIG_W'(3): w_glyph = GL_F;
            default:   w_glyph = GL_BLANK;
         endcase
      end else begin
         w_glyph = {1'b0, w_nib[r_digit]};
         w_dot   = (r_digit == DIG_W'(SCORE_DIGITS));
      end
   end

   hud_seg7_decoder u_seg7_decoder (
      .i_glyph (w_glyph),
      .i_dot   (w_dot),
      .o_seg   (w_seg)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_stb_cnt    <= '0;
         r_digit      <= '0;
         r_seg_select <= '1;
         r_dec_out    <= '1;
      end else begin
         if (r_stb_cnt == STB_LAST) begin
            r_stb_cnt <= '0;
            r_digit   <= (r_digit == DIG_LAST) ? '0 : r_digit + DIG_W'(1);
         end else begin
            r_stb_cnt <= r_stb_cnt + STB_W'(1);
         end
         r_seg_select <= ~(NUM_DIGITS'(1) << r_digit);
         r_dec_out    <= w_seg;
      end
   end

   assign SEG_SELECT = r_seg_select;
   assign DEC_OUT    = r_dec_out;
   assign SCORE      = r_score;
   assign TIME_LEFT  = r_time;
   assign TIME_IS_UP = r_time_up;

endmodule

// File: tb/tb_snake_hud_controller.sv
// Self-checking bench for snake_hud_controller (SEC_DIV=10, STROBE_DIV=4, 60 s, 2+2 digits).
module tb_snake_hud_controller;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [1:0] PLAY_STATE;
   logic       REACHED_TARGET;
   logic [3:0] SEG_SELECT;
   logic [7:0] DEC_OUT;
   logic [7:0] SCORE;
   logic [7:0] TIME_LEFT;
   logic       TIME_IS_UP;

   int n_checks = 0;
   int n_errors = 0;
   int m_score  = 0;
   logic [7:0] sb_q[$];

   typedef struct {
      int         pulses;
      int         run_clks;
      logic [7:0] exp_score;
      logic [7:0] exp_time;
      logic       exp_up;
   } vec_t;
   vec_t vecs[6];

   logic [6:0] seg_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   snake_hud_controller #(
      .SCORE_DIGITS (2),
      .TIME_DIGITS  (2),
      .GAME_SECONDS (60),
      .SEC_DIV      (10),
      .STROBE_DIV   (4)
   ) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .PLAY_STATE     (PLAY_STATE),
      .REACHED_TARGET (REACHED_TARGET),
      .SEG_SELECT     (SEG_SELECT),
      .DEC_OUT        (DEC_OUT),
      .SCORE          (SCORE),
      .TIME_LEFT      (TIME_LEFT),
      .TIME_IS_UP     (TIME_IS_UP)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      if (n > 0) repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [7:0] digit_seg(input int d, input bit dot);
      logic [6:0] s;
      s = seg_tab[d];
      return {~dot, s};
   endfunction

   task automatic pulse(input bit counted);
      logic [7:0] exp;
      REACHED_TARGET = 1'b1;
      if (counted && m_score < 99) m_score++;
      sb_q.push_back(to_bcd(m_score));
      tick(1);
      REACHED_TARGET = 1'b0;
      exp = sb_q.pop_front();
      check("score_sb", SCORE, exp);
      tick(1);
   endtask

   task automatic start_game();
      PLAY_STATE = 2'b00;
      tick(1);
      PLAY_STATE = 2'b01;
      tick(1);
      m_score = 0;
   endtask

   task automatic check_display(input string name, input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
      logic [3:0] prev;
      logic [7:0] exp[4];
      logic [3:0] sel;
      bit found;
      exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
      found = 1'b0;
      prev = SEG_SELECT;
      for (int k = 0; k < 24 && !found; k++) begin
         tick(1);
         if (SEG_SELECT == 4'b1110 && prev != 4'b1110) found = 1'b1;
         prev = SEG_SELECT;
      end
      check({name, "_align"}, 32'(found), 32'd1);
      for (int d = 0; d < 4; d++) begin
         sel = ~(4'b0001 << d);
         check({name, "_sel"}, SEG_SELECT, sel);
         check({name, "_dec"}, DEC_OUT, exp[d]);
         tick(4);
      end
   endtask

   initial begin
      vecs[0] = '{0,   9,   8'h00, 8'h60, 1'b0};
      vecs[1] = '{0,   10,  8'h00, 8'h59, 1'b0};
      vecs[2] = '{12,  30,  8'h12, 8'h57, 1'b0};
      vecs[3] = '{5,   300, 8'h05, 8'h30, 1'b0};
      vecs[4] = '{120, 240, 8'h99, 8'h36, 1'b0};
      vecs[5] = '{99,  598, 8'h99, 8'h01, 1'b0};

      RESET = 1'b1;
      PLAY_STATE = 2'b00;
      REACHED_TARGET = 1'b0;
      tick(3);
      check("rst_score", SCORE, 8'h00);
      check("rst_time", TIME_LEFT, 8'h60);
      check("rst_up", TIME_IS_UP, 1'b0);
      check("rst_sel", SEG_SELECT, 4'hF);
      check("rst_dec", DEC_OUT, 8'hFF);
      RESET = 1'b0;
      tick(1);

      for (int v = 0; v < 6; v++) begin
         start_game();
         for (int p = 0; p < vecs[v].pulses; p++) pulse(1'b1);
         tick(vecs[v].run_clks - 2 * vecs[v].pulses);
         check("vec_score", SCORE, vecs[v].exp_score);
         check("vec_time", TIME_LEFT, vecs[v].exp_time);
         check("vec_up", TIME_IS_UP, vecs[v].exp_up);
      end

      // Pulse landing on the final decrement, then expiry.
      start_game();
      tick(599);
      check("final_time01", TIME_LEFT, 8'h01);
      REACHED_TARGET = 1'b1;
      m_score++;
      sb_q.push_back(to_bcd(m_score));
      tick(1);
      REACHED_TARGET = 1'b0;
      check("final_score", SCORE, sb_q.pop_front());
      check("final_time00", TIME_LEFT, 8'h00);
      check("final_up_lag", TIME_IS_UP, 1'b0);
      tick(1);
      check("final_up_set", TIME_IS_UP, 1'b1);
      pulse(1'b0);
      tick(20);
      check("expired_up", TIME_IS_UP, 1'b1);
      check("expired_time", TIME_LEFT, 8'h00);

      start_game();
      check("restart_up", TIME_IS_UP, 1'b0);
      check("restart_time", TIME_LEFT, 8'h60);
      check("restart_score", SCORE, 8'h00);

      // Win freezes the timer and ignores targets.
      for (int p = 0; p < 3; p++) pulse(1'b1);
      tick(44);
      check("freeze_t50", TIME_LEFT, 8'h55);
      PLAY_STATE = 2'b10;
      tick(3);
      for (int p = 0; p < 5; p++) pulse(1'b0);
      tick(87);
      check("freeze_time", TIME_LEFT, 8'h55);
      check("freeze_score", SCORE, 8'h03);
      check_display("win_disp", digit_seg(3, 0), digit_seg(0, 0), digit_seg(5, 1), digit_seg(5, 0));

      PLAY_STATE = 2'b11;
      tick(2);
      check_display("fail_disp", 8'hC7, 8'hCF, 8'h88, 8'h8E);

      // Reset in mid-game.
      start_game();
      for (int p = 0; p < 5; p++) pulse(1'b1);
      tick(290);
      check("pre_rst_time", TIME_LEFT, 8'h30);
      check("pre_rst_score", SCORE, 8'h05);
      RESET = 1'b1;
      tick(1);
      check("mid_rst_score", SCORE, 8'h00);
      check("mid_rst_time", TIME_LEFT, 8'h60);
      check("mid_rst_up", TIME_IS_UP, 1'b0);
      RESET = 1'b0;
      m_score = 0;
      tick(20);
      check("no_edge_time", TIME_LEFT, 8'h60);
      pulse(1'b0);
      start_game();
      tick(10);
      check("fresh_edge_time", TIME_LEFT, 8'h59);

      // Two games (7 then 3), then idle display.
      start_game();
      for (int p = 0; p < 7; p++) pulse(1'b1);
      PLAY_STATE = 2'b00;
      tick(2);
      start_game();
      for (int p = 0; p < 3; p++) pulse(1'b1);
      PLAY_STATE = 2'b00;
      tick(2);
      check("idle_score", SCORE, 8'h03);
`ifdef HUD_HIGHSCORE_EN
      check_display("idle_best", digit_seg(7, 0), digit_seg(0, 0), digit_seg(0, 1), digit_seg(6, 0));
`else
      check_display("idle_last", digit_seg(3, 0), digit_seg(0, 0), digit_seg(0, 1), digit_seg(6, 0));
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
